// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the registered ULA control decoder.
//   - SEL_*      : ALU select codes driven on ula_select
//   - ULA_OP_*   : main-control ula_op encodings
//   - *_HI/*_LO  : field positions inside the 17-bit inst bundle
//   - F7_*       : funct7 patterns that change the decode
//   - md_state_e : muldiv sequencing FSM states
//   - base_sel() : funct3 -> select for the plain (funct7 = 0) ALU ops
package ula_pkg;

    localparam logic [3:0] SEL_ADD   = 4'd0;
    localparam logic [3:0] SEL_SUB   = 4'd1;
    localparam logic [3:0] SEL_SLL   = 4'd2;
    localparam logic [3:0] SEL_SLT   = 4'd3;
    localparam logic [3:0] SEL_SLTU  = 4'd4;
    localparam logic [3:0] SEL_XOR   = 4'd5;
    localparam logic [3:0] SEL_SRL   = 4'd6;
    localparam logic [3:0] SEL_SRA   = 4'd7;
    localparam logic [3:0] SEL_OR    = 4'd8;
    localparam logic [3:0] SEL_AND   = 4'd9;
    localparam logic [3:0] SEL_PASSB = 4'd10;
    localparam logic [3:0] SEL_ADDPC = 4'd11;
    localparam logic [3:0] SEL_MD    = 4'd12;

    localparam logic [2:0] ULA_OP_MEM    = 3'b000;
    localparam logic [2:0] ULA_OP_BRANCH = 3'b001;
    localparam logic [2:0] ULA_OP_RTYPE  = 3'b010;
    localparam logic [2:0] ULA_OP_ITYPE  = 3'b011;
    localparam logic [2:0] ULA_OP_LUI    = 3'b100;
    localparam logic [2:0] ULA_OP_AUIPC  = 3'b101;

    localparam int OPC_HI = 16;
    localparam int OPC_LO = 10;
    localparam int F3_HI  = 9;
    localparam int F3_LO  = 7;
    localparam int F7_HI  = 6;
    localparam int F7_LO  = 0;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MD_START = 2'd1,
        ST_MD_WAIT  = 2'd2
    } md_state_e;

    function automatic logic [3:0] base_sel(input logic [2:0] f3);
        logic [3:0] s;
        case (f3)
            3'b000:  s = SEL_ADD;
            3'b001:  s = SEL_SLL;
            3'b010:  s = SEL_SLT;
            3'b011:  s = SEL_SLTU;
            3'b100:  s = SEL_XOR;
            3'b101:  s = SEL_SRL;
            3'b110:  s = SEL_OR;
            default: s = SEL_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ula_control_md_if.sv
// ula_control_md_if: request/response and muldiv handshake bundle.
//   master : decode-stage requester, output consumer and muldiv unit (drives
//            in_valid/inst/ula_op/out_ready/md_done)
//   slave  : ula_control_md (drives in_ready/out_valid/ula_select/illegal/
//            md_start/md_op)
interface ula_control_md_if #(
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [16:0]      inst;
    logic [2:0]       ula_op;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] ula_select;
    logic             illegal;
    logic             md_start;
    logic [2:0]       md_op;
    logic             md_done;

    modport master (
        output in_valid, inst, ula_op, out_ready, md_done,
        input  in_ready, out_valid, ula_select, illegal, md_start, md_op
    );

    modport slave (
        input  in_valid, inst, ula_op, out_ready, md_done,
        output in_ready, out_valid, ula_select, illegal, md_start, md_op
    );
endinterface

// File: rtl/ula_decode.sv
// ula_decode: combinational {inst, ula_op} -> {select, illegal, is_md}.
//   inst    [16:10] opcode (not needed, ula_op already classifies it),
//           [9:7] funct3, [6:0] funct7
//   ula_op  main-control operation class
//   select  ALU select code, forced to SEL_ADD on illegal encodings
//   illegal encoding is not a legal operation
//   is_md   M-extension op; only asserted when ULA_M_EXT_EN is defined
module ula_decode
    import ula_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic [16:0]      inst,
    input  logic [2:0]       ula_op,
    output logic [SEL_W-1:0] select,
    output logic             illegal,
    output logic             is_md
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] unused_opcode;
    logic [3:0] sel_c;
    logic       ill_c;
    logic       md_c;

    assign f3            = inst[F3_HI:F3_LO];
    assign f7            = inst[F7_HI:F7_LO];
    assign unused_opcode = inst[OPC_HI:OPC_LO];

    always_comb begin
        sel_c = SEL_ADD;
        ill_c = 1'b0;
        md_c  = 1'b0;
        case (ula_op)
            ULA_OP_MEM:    sel_c = SEL_ADD;
            ULA_OP_BRANCH: sel_c = SEL_SUB;
            ULA_OP_RTYPE: begin
                if (f7 == F7_BASE) begin
                    sel_c = base_sel(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    sel_c = SEL_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    sel_c = SEL_SRA;
`ifdef ULA_M_EXT_EN
                end else if (f7 == F7_MULDIV) begin
                    sel_c = SEL_MD;
                    md_c  = 1'b1;
`endif
                end else begin
                    ill_c = 1'b1;
                end
            end
            ULA_OP_ITYPE: begin
                // funct7 only matters for the shift-immediate forms
                case (f3)
                    3'b001: begin
                        sel_c = SEL_SLL;
                        ill_c = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     sel_c = SEL_SRL;
                        else if (f7 == F7_ALT) sel_c = SEL_SRA;
                        else                   ill_c = 1'b1;
                    end
                    default: sel_c = base_sel(f3);
                endcase
            end
            ULA_OP_LUI:   sel_c = SEL_PASSB;
            ULA_OP_AUIPC: sel_c = SEL_ADDPC;
            default:      ill_c = 1'b1;
        endcase
        if (ill_c) sel_c = SEL_ADD;
    end

    assign select  = SEL_W'(sel_c);
    assign illegal = ill_c;
    assign is_md   = md_c;

endmodule

// File: rtl/ula_control_md.sv
// ula_control_md: registered, handshaked ULA control decoder with optional
// multi-cycle M-extension sequencing against an external iterative muldiv.
// Build option: ULA_M_EXT_EN enables the muldiv FSM; without it funct7=0000001
// R-type ops decode as illegal and md_start/md_op are tied low.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ula_control_md_if.slave: in_valid/in_ready/inst/ula_op request,
//          out_valid/out_ready/ula_select/illegal response,
//          md_start/md_op/md_done muldiv handshake
//
//   state       | meaning
//   ST_IDLE     | accepting requests, output register drains normally
//   ST_MD_START | one-cycle md_start pulse to the muldiv unit
//   ST_MD_WAIT  | waiting for md_done, bounded by MD_TIMEOUT cycles
module ula_control_md
    import ula_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = $clog2(MD_TIMEOUT)
) (
    input logic                clk,
    input logic                rst_n,
    ula_control_md_if.slave    bus
);

    logic [SEL_W-1:0] dec_sel;
    logic             dec_ill;
    logic             dec_md;

    ula_decode #(.SEL_W(SEL_W)) u_decode (
        .inst    (bus.inst),
        .ula_op  (bus.ula_op),
        .select  (dec_sel),
        .illegal (dec_ill),
        .is_md   (dec_md)
    );

    logic             out_valid_q;
    logic [SEL_W-1:0] sel_q;
    logic             ill_q;
    logic             in_ready_c;
    logic             accept;
    logic             md_fin;
    logic             md_to;

    assign accept = bus.in_valid && in_ready_c;

`ifdef ULA_M_EXT_EN
    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       md_op_q;
    logic             md_start_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        md_start_c = 1'b0;
        md_fin     = 1'b0;
        md_to      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec_md) state_d = ST_MD_START;
            end
            ST_MD_START: begin
                md_start_c = 1'b1;
                state_d    = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                if (bus.md_done) begin
                    md_fin  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    md_fin  = 1'b1;
                    md_to   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter sits at zero outside MD_WAIT, so MD_WAIT always starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt_q <= '0;
        else if (state_q != ST_MD_WAIT) cnt_q <= '0;
        else if (!md_fin)              cnt_q <= cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 md_op_q <= 3'b000;
        else if (accept && dec_md)  md_op_q <= bus.inst[F3_HI:F3_LO];
    end

    assign in_ready_c   = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.md_start = md_start_c;
    assign bus.md_op    = md_op_q;
`else
    logic unused_md_done;

    assign unused_md_done = bus.md_done;
    assign md_fin         = 1'b0;
    assign md_to          = 1'b0;
    assign in_ready_c     = !out_valid_q || bus.out_ready;
    assign bus.md_start   = 1'b0;
    assign bus.md_op      = 3'b000;
`endif

    // Accepting an M op loads nothing; the register simply drains (in_ready
    // guarantees it is empty or being consumed) and waits for the muldiv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sel_q       <= SEL_W'(SEL_ADD);
            ill_q       <= 1'b0;
        end else if (accept && !dec_md) begin
            out_valid_q <= 1'b1;
            sel_q       <= dec_sel;
            ill_q       <= dec_ill;
        end else if (md_fin) begin
            out_valid_q <= 1'b1;
            sel_q       <= SEL_W'(SEL_MD);
            ill_q       <= md_to;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.ula_select = sel_q;
    assign bus.illegal    = ill_q;

endmodule

// File: tb/tb_ula_control_md.sv
// tb_ula_control_md: directed + randomized checks of ula_control_md against a
// transaction-level reference model (decode rules plus a one-deep output queue).
module tb_ula_control_md;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst_n;

    ula_control_md_if #(.SEL_W(4)) bus ();

    ula_control_md #(.SEL_W(4), .MD_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
        return {opc, f3, f7};
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic void ref_decode(input logic [16:0] i, input logic [2:0] op,
                                       output int sel, output bit ill);
        int plain [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int f3 = int'(i[9:7]);
        int f7 = int'(i[6:0]);
        sel = 0;
        ill = 1'b0;
        case (op)
            3'd0: sel = 0;
            3'd1: sel = 1;
            3'd2: begin
                if (f7 == 0)                  sel = plain[f3];
                else if (f7 == 32 && f3 == 0) sel = 1;
                else if (f7 == 32 && f3 == 5) sel = 7;
                else                          ill = 1'b1;
            end
            3'd3: begin
                if (f3 == 1 && f7 != 0)                   ill = 1'b1;
                else if (f3 == 5 && f7 == 32)             sel = 7;
                else if (f3 == 5 && f7 != 0)              ill = 1'b1;
                else                                      sel = plain[f3];
            end
            3'd4: sel = 10;
            3'd5: sel = 11;
            default: ill = 1'b1;
        endcase
        if (ill) sel = 0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [16:0] b2b_inst [4];
    int          b2b_sel  [4] = '{1, 2, 7, 9};
    int          q_sel [$];
    bit          q_ill [$];
    int          rs;
    bit          ri;
    logic [6:0]  rf7;
    logic        exp_rdy;

    initial begin
        b2b_inst[0] = mk(7'h33, 3'b000, 7'h20);
        b2b_inst[1] = mk(7'h33, 3'b001, 7'h00);
        b2b_inst[2] = mk(7'h33, 3'b101, 7'h20);
        b2b_inst[3] = mk(7'h33, 3'b111, 7'h00);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inst      = '0;
        bus.ula_op    = 3'b000;
        bus.out_ready = 1'b1;
        bus.md_done   = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sel", 32'(bus.ula_select), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_md_start", 32'(bus.md_start), 0);
        chk("rst_md_op", 32'(bus.md_op), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // 1: branch compare -> SUB
        bus.in_valid = 1'b1;
        bus.inst     = 17'h0CC00;
        bus.ula_op   = 3'b001;
        step();
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_sel", 32'(bus.ula_select), 1);
        chk("t1_ill", 32'(bus.illegal), 0);

        // 2: back-to-back R-type, then backpressure
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.inst     = b2b_inst[k];
            bus.ula_op   = 3'b010;
            #1;
            chk("t2_in_ready", 32'(bus.in_ready), 1);
            step();
            chk("t2_valid", 32'(bus.out_valid), 1);
            chk("t2_sel", 32'(bus.ula_select), 32'(b2b_sel[k]));
        end
        bus.out_ready = 1'b0;
        bus.inst      = b2b_inst[1];
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_hold_in_ready", 32'(bus.in_ready), 0);
            step();
            chk("t2_hold_valid", 32'(bus.out_valid), 1);
            chk("t2_hold_sel", 32'(bus.ula_select), 9);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t2_release_in_ready", 32'(bus.in_ready), 1);
        step();
        chk("t2_release_sel", 32'(bus.ula_select), 2);
        bus.in_valid = 1'b0;
        step();
        chk("t2_drained", 32'(bus.out_valid), 0);

        // 3: I-type and reserved ula_op
        bus.in_valid = 1'b1;
        bus.ula_op   = 3'b011;
        bus.inst     = mk(7'h13, 3'b101, 7'h20);
        step();
        chk("t3_srai_sel", 32'(bus.ula_select), 7);
        chk("t3_srai_ill", 32'(bus.illegal), 0);
        bus.inst = mk(7'h13, 3'b001, 7'h20);
        step();
        chk("t3_slli_bad_sel", 32'(bus.ula_select), 0);
        chk("t3_slli_bad_ill", 32'(bus.illegal), 1);
        bus.inst   = mk(7'h13, 3'b000, 7'h20);
        step();
        chk("t3_addi_sel", 32'(bus.ula_select), 0);
        chk("t3_addi_ill", 32'(bus.illegal), 0);
        bus.ula_op = 3'b110;
        step();
        chk("t3_rsvd_ill", 32'(bus.illegal), 1);
        chk("t3_rsvd_valid", 32'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        step();

`ifdef ULA_M_EXT_EN
        // 4: DIV completes via md_done
        bus.in_valid = 1'b1;
        bus.ula_op   = 3'b010;
        bus.inst     = mk(7'h33, 3'b100, 7'h01);
        step();
        bus.in_valid = 1'b0;
        chk("t4_md_start", 32'(bus.md_start), 1);
        chk("t4_md_op", 32'(bus.md_op), 4);
        chk("t4_in_ready0", 32'(bus.in_ready), 0);
        chk("t4_valid0", 32'(bus.out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_wait_start", 32'(bus.md_start), 0);
            chk("t4_wait_op", 32'(bus.md_op), 4);
            chk("t4_wait_in_ready", 32'(bus.in_ready), 0);
            chk("t4_wait_valid", 32'(bus.out_valid), 0);
        end
        bus.md_done = 1'b1;
        step();
        bus.md_done = 1'b0;
        chk("t4_done_valid", 32'(bus.out_valid), 1);
        chk("t4_done_sel", 32'(bus.ula_select), 12);
        chk("t4_done_ill", 32'(bus.illegal), 0);
        chk("t4_done_in_ready", 32'(bus.in_ready), 1);
        step();

        // 5: timeout after T wait cycles
        bus.in_valid = 1'b1;
        bus.inst     = mk(7'h33, 3'b110, 7'h01);
        step();
        bus.in_valid = 1'b0;
        chk("t5_md_start", 32'(bus.md_start), 1);
        for (int k = 0; k < T; k++) begin
            step();
            chk("t5_wait_valid", 32'(bus.out_valid), 0);
            chk("t5_wait_in_ready", 32'(bus.in_ready), 0);
        end
        step();
        chk("t5_to_valid", 32'(bus.out_valid), 1);
        chk("t5_to_sel", 32'(bus.ula_select), 12);
        chk("t5_to_ill", 32'(bus.illegal), 1);
        chk("t5_to_in_ready", 32'(bus.in_ready), 1);
        step();

        // 6: reset during MD_WAIT, stale md_done afterwards
        bus.in_valid = 1'b1;
        bus.inst     = mk(7'h33, 3'b000, 7'h01);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 32'(bus.md_start), 0);
        chk("t6_rst_valid", 32'(bus.out_valid), 0);
        chk("t6_rst_in_ready", 32'(bus.in_ready), 1);
        step();
        rst_n       = 1'b1;
        bus.md_done = 1'b1;
        step();
        bus.md_done = 1'b0;
        chk("t6_stale_valid", 32'(bus.out_valid), 0);
        chk("t6_stale_start", 32'(bus.md_start), 0);
        step();
        chk("t6_stale_valid2", 32'(bus.out_valid), 0);
`else
        // 6: M op without the extension is a one-cycle illegal
        bus.in_valid = 1'b1;
        bus.ula_op   = 3'b010;
        bus.inst     = mk(7'h33, 3'b100, 7'h01);
        step();
        bus.in_valid = 1'b0;
        chk("t6_nom_valid", 32'(bus.out_valid), 1);
        chk("t6_nom_ill", 32'(bus.illegal), 1);
        chk("t6_nom_sel", 32'(bus.ula_select), 0);
        chk("t6_nom_start", 32'(bus.md_start), 0);
        step();
        chk("t6_nom_start2", 32'(bus.md_start), 0);
        chk("t6_nom_drained", 32'(bus.out_valid), 0);
`endif

        // Randomized traffic against a one-deep output queue model.
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", 32'(bus.out_valid), 32'(q_sel.size() != 0));
            if (q_sel.size() != 0) begin
                chk("rnd_sel", 32'(bus.ula_select), 32'(q_sel[0]));
                chk("rnd_ill", 32'(bus.illegal), 32'(q_ill[0]));
            end
            chk("rnd_md_start", 32'(bus.md_start), 0);
            rf7 = 7'($urandom);
            case ($urandom % 4)
                0: rf7 = 7'h00;
                1: rf7 = 7'h20;
                2: rf7 = 7'h01;
                default: ;
            endcase
`ifdef ULA_M_EXT_EN
            if (rf7 == 7'h01) rf7 = 7'h00;
`endif
            bus.inst      = mk(7'($urandom), 3'($urandom), rf7);
            bus.ula_op    = 3'($urandom);
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            #1;
            exp_rdy = (q_sel.size() == 0) || bus.out_ready;
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (q_sel.size() != 0 && bus.out_ready) begin
                void'(q_sel.pop_front());
                void'(q_ill.pop_front());
            end
            if (bus.in_valid && exp_rdy) begin
                ref_decode(bus.inst, bus.ula_op, rs, ri);
                q_sel.push_back(rs);
                q_ill.push_back(ri);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ula_control_md.md
Name: ula_control_md

Overview:
- Registered, handshaked successor of the combinational ULA control decoder. It decodes {opcode, funct3, funct7} plus the main-control ula_op into an ALU select code.
- Adds a valid/ready output stage, illegal-encoding detection, and an FSM that sequences multi-cycle M-extension ops (MUL/DIV/REM) against an external iterative muldiv unit, with a timeout.
- Sits between main control (decode stage) and the ULA/muldiv datapath in the execute stage.

Parameters:
- SEL_W, 4, width of ula_select (must be >=4)
- MD_TIMEOUT, 64, max cycles spent in MD_WAIT before abort (>=2)
- CNT_W, $clog2(MD_TIMEOUT), timeout counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- inst  in  17  [16:10] opcode, [9:7] funct3, [6:0] funct7
- ula_op  in  3  000 mem/add, 001 branch, 010 R-type, 011 I-type, 100 LUI, 101 AUIPC, 110/111 reserved
- out_valid  out  1  output register holds result
- out_ready  in  1  consumer takes output when out_valid && out_ready
- ula_select  out  SEL_W  ALU operation code
- illegal  out  1  qualifies the output: illegal encoding or muldiv timeout
- md_start  out  1  single-cycle start pulse to muldiv unit
- md_op  out  3  funct3 of the M op; held stable from md_start until MD_WAIT exits
- md_done  in  1  muldiv completion pulse

Behaviour:
- Reset values:
  - out_valid=0, ula_select=SEL_ADD (0), illegal=0, md_start=0, md_op=0.
  - FSM=IDLE, timeout counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational, with no in_valid dependency.
- Select codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - PASSB=10 (LUI), ADDPC=11 (AUIPC), MD=12 (result taken from muldiv).
- Decode by ula_op:
  - 000 -> ADD.
  - 001 -> SUB (branch compare).
  - 010 -> funct3/funct7:
    - funct7=0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
    - funct7=0000001 is an M op (see Optional Feature).
    - Anything else is illegal.
  - 011 -> funct3 decode with funct7 ignored, except:
    - funct3=001 requires funct7=0000000.
    - funct3=101 requires funct7 0000000 (SRL) or 0100000 (SRA).
    - funct3=000 is always ADD; there is no SUBI.
  - 100 -> PASSB.
  - 101 -> ADDPC.
  - 110/111 -> illegal.
- Illegal result: ula_select=SEL_ADD, illegal=1, delivered through the normal output path. It is never dropped.
- Single-cycle ops: the accept cycle loads the output register. Latency is 1 cycle and throughput is 1/cycle with out_ready held high. Output is held stable while out_valid && !out_ready.
- FSM states IDLE, MD_START, MD_WAIT:
  - IDLE: accepting an M op -> MD_START, latch md_op=funct3; the output register drains or clears that cycle (out_valid=0).
  - MD_START: md_start=1 for exactly this cycle -> MD_WAIT, counter cleared.
  - MD_WAIT: md_done=1 -> load output (SEL_MD, illegal=0), -> IDLE. Otherwise, counter==MD_TIMEOUT-1 -> load output (SEL_MD, illegal=1), -> IDLE. Otherwise increment counter.
- md_done is sampled only in MD_WAIT and ignored in IDLE/MD_START.
- in_valid during MD_START/MD_WAIT is not accepted (in_ready=0); the requester holds inst/ula_op.
- Reset asserted mid-operation: immediately IDLE, out_valid=0, md_start=0; any in-flight M op is abandoned.

Optional Feature:
- Macro: ULA_M_EXT_EN.
- Defined: funct7=0000001 with ula_op=010 runs the MD FSM as above.
- Undefined:
  - funct7=0000001 decodes as illegal (single-cycle path).
  - MD_START/MD_WAIT and the counter are not built.
  - md_start and md_op are tied to 0 and md_done is unused.
  - in_ready = !out_valid || out_ready.

Decomposition:
- Package ula_pkg holds:
  - SEL_* select constants.
  - ULA_OP_* constants.
  - Field index localparams (OPC_HI/LO, F3_HI/LO, F7_HI/LO).
  - F7_BASE / F7_ALT / F7_MULDIV.
  - The FSM state enum.
- One natural combinational sub-module, ula_decode: inst/ula_op -> {select, illegal, is_md}. The top holds the FSM, counter and output register.

Test Plan:
1. After reset release: out_valid=0, ula_select=0, in_ready=1. Then inst=0x0CC00 (ADD) with ula_op=001 -> next cycle out_valid=1, ula_select=1 (SUB).
2. Back-to-back R-type with out_ready=1: SUB, SLL, SRA, AND, ula_op=010 -> selects 1, 2, 7, 9 on consecutive cycles, no bubbles. Then out_ready=0 for 3 cycles: output held, in_ready=0.
3. I-type with ula_op=011: SRA inst (funct7=0100000, funct3=101) -> 7. SLL with funct7=0100000 -> illegal=1, select=0. ula_op=110 -> illegal=1.
4. With ULA_M_EXT_EN, inst funct7=0000001 funct3=100 (DIV):
   - md_start pulses exactly 1 cycle with md_op=100.
   - md_done returns 5 cycles later -> out_valid=1, select=12, illegal=0.
   - in_ready=0 throughout.
5. MD timeout with MD_TIMEOUT=8 and md_done never asserted -> output select=12, illegal=1, returned to IDLE with in_ready=1.
6. rst_n asserted during MD_WAIT: state IDLE, md_start=0, out_valid=0 asynchronously. A stale md_done after release produces no output. Without the macro, the same M inst -> illegal=1 in 1 cycle and md_start never asserts.
